// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, fetch FSM state and fetch-queue entry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    FETCH,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    word_t pc;
    word_t ins;
  } fetch_entry_t;

endpackage

// File: rtl/mux_types_pkg.sv
// Mux select encodings driven by decode into the datapath.
package mux_types_pkg;

  typedef enum logic [1:0] {
    PC_NEXT,
    PC_BRANCH,
    PC_JUMP,
    PC_JR
  } pcMux;

endpackage

// File: rtl/fetch_queue.sv
// Parameterised synchronous FIFO; flush empties it, and push+pop while full is allowed.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from imem, queues them for decode.
module fetch_unit
  import cpu_types_pkg::*;
  import mux_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] npc,
  input  logic        stall,
  input  pcMux        pcSel,
  input  logic [31:0] branch_target,
  input  logic [25:0] immJ26,
  input  logic [31:0] jr_target,
  input  logic        halt
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t state, state_next;
  word_t        pc, pc_next;
  word_t        head_npc;
  word_t        redirect_pc;
  fetch_entry_t head;
  logic         q_full, q_empty;
  logic [CW-1:0] q_count;
  logic         push, pop, flush;
  logic         halt_take, redirect;

  assign ins_valid = (q_count != '0);
  assign ins       = q_empty ? '0 : head.ins;
  assign head_npc  = head.pc + 32'd4;
  assign npc       = ins_valid ? head_npc : pc + 32'd4;
  assign imemaddr  = pc;

  // Halt wins over any redirect; redirects only count when decode accepts the head.
  assign halt_take = ins_valid & halt;
  assign pop       = ins_valid & ~stall & ~halt;
  assign redirect  = pop & (pcSel != PC_NEXT);

  always_comb begin
    redirect_pc = pc;
    case (pcSel)
      PC_BRANCH: redirect_pc = branch_target;
      PC_JUMP:   redirect_pc = {head_npc[31:28], immJ26, 2'b00};
      PC_JR:     redirect_pc = jr_target & 32'hFFFF_FFFC;
      default:   redirect_pc = pc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
      pc    <= PC_INIT;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    imemREN    = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    case (state)
      FETCH: begin
        if (halt_take) begin
          state_next = HALTED;
          flush      = 1'b1;
        end else if (redirect) begin
          flush   = 1'b1;
          pc_next = redirect_pc;
        end else begin
          imemREN = ~q_full | pop;
          push    = imemREN & ihit;
          if (push) pc_next = pc + 32'd4;
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = FETCH;
    endcase
    if (RST) begin
      imemREN = 1'b0;
      push    = 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({pc, imemload}),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-level reference model plus directed literal checks.
module tb_fetch_unit;
  import mux_types_pkg::*;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, halt;
  logic        imemREN, ins_valid;
  logic [31:0] imemaddr, imemload, ins, npc, branch_target, jr_target;
  logic [25:0] immJ26;
  pcMux        pcSel;

  int checkCount = 0;
  int errorCount = 0;
  bit checkEn = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] mpc;
  bit          mhalted;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign imemload = memWord(imemaddr);

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(PC_INIT), .BUF_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .ins(ins), .ins_valid(ins_valid), .npc(npc), .stall(stall),
    .pcSel(pcSel), .branch_target(branch_target), .immJ26(immJ26),
    .jr_target(jr_target), .halt(halt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a list of {pc,word} entries and a PC, advanced once per clock.
  always @(posedge CLK) begin
    bit v, pop, fetch;
    logic [31:0] hn;
    v = mq.size() > 0;
    if (RST) begin
      mq.delete();
      mpc = PC_INIT;
      mhalted = 0;
    end else if (!mhalted) begin
      if (v && halt) begin
        mhalted = 1;
        mq.delete();
      end else if (v && !stall && pcSel != PC_NEXT) begin
        hn = mq[0].pc + 32'd4;
        case (pcSel)
          PC_BRANCH: mpc = branch_target;
          PC_JUMP:   mpc = {hn[31:28], immJ26, 2'b00};
          default:   mpc = jr_target & 32'hFFFF_FFFC;
        endcase
        mq.delete();
      end else begin
        pop   = v && !stall;
        fetch = (mq.size() < 2) || pop;
        if (pop) void'(mq.pop_front());
        if (fetch && ihit) begin
          mq.push_back('{pc: mpc, word: memWord(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  always @(negedge CLK) begin
    bit v, expRen;
    if (checkEn) begin
      v = mq.size() > 0;
      expRen = !RST && !mhalted && !(v && halt) && !(v && !stall && pcSel != PC_NEXT)
               && ((mq.size() < 2) || (v && !stall));
      checkOutput("model_imemREN", imemREN, expRen);
      checkOutput("model_imemaddr", imemaddr, mpc);
      checkOutput("model_ins_valid", ins_valid, v);
      if (v) begin
        checkOutput("model_ins", ins, mq[0].word);
        checkOutput("model_npc", npc, mq[0].pc + 32'd4);
      end else begin
        checkOutput("model_ins_empty", ins, 32'h0);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic stl, input logic hlt,
                               input logic ih, input pcMux sel);
    @(posedge CLK);
    #1;
    RST = rst; stall = stl; halt = hlt; ihit = ih; pcSel = sel;
    @(negedge CLK);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, PC_NEXT);
  endtask

  task automatic runCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, PC_NEXT);
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; halt = 1'b0; ihit = 1'b0; pcSel = PC_NEXT;
    branch_target = 32'h0; jr_target = 32'h0; immJ26 = 26'h0;
    @(posedge CLK);
    #1 checkEn = 1;

    // Reset state and streaming fetch.
    resetCycle();
    checkOutput("rst_imemREN", imemREN, 0);
    checkOutput("rst_ins_valid", ins_valid, 0);
    checkOutput("rst_ins", ins, 32'h0);
    checkOutput("rst_npc", npc, PC_INIT + 32'd4);
    runCycle();
    checkOutput("t1_addr0", imemaddr, 32'h0);
    checkOutput("t1_not_valid_yet", ins_valid, 0);
    runCycle();
    checkOutput("t1_ins0", ins, 32'hBEEF_0000);
    checkOutput("t1_npc0", npc, 32'h4);
    checkOutput("t1_addr1", imemaddr, 32'h4);
    runCycle();
    checkOutput("t1_ins1", ins, 32'hBEEB_0004);
    for (int i = 0; i < 4; i++) runCycle();

    // Stall fills the queue, then pop+push keeps it full.
    resetCycle();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, PC_NEXT);
    checkOutput("t2_full_ren", imemREN, 0);
    checkOutput("t2_full_addr", imemaddr, 32'h8);
    checkOutput("t2_head", ins, 32'hBEEF_0000);
    runCycle();
    checkOutput("t2_poppush_ren", imemREN, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, PC_NEXT);
    checkOutput("t2_still_full", imemREN, 0);
    checkOutput("t2_head_next", ins, 32'hBEEB_0004);
    checkOutput("t2_addr", imemaddr, 32'hC);

    // Branch with a same-cycle ihit.
    resetCycle();
    for (int i = 0; i < 5; i++) runCycle();
    branch_target = 32'h40;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, PC_BRANCH);
    checkOutput("t3_head_npc", npc, 32'h14);
    checkOutput("t3_redirect_ren", imemREN, 0);
    runCycle();
    checkOutput("t3_flushed", ins_valid, 0);
    checkOutput("t3_target_addr", imemaddr, 32'h40);
    runCycle();
    checkOutput("t3_target_ins", ins, 32'hBEAF_0040);

    // Jump keeps npc[31:28]; jr clears the low bits.
    resetCycle();
    runCycle();
    branch_target = 32'h8000_0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, PC_BRANCH);
    runCycle();
    checkOutput("t4_hi_addr", imemaddr, 32'h8000_0000);
    immJ26 = 26'h10;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, PC_JUMP);
    checkOutput("t4_jump_npc", npc, 32'h8000_0004);
    runCycle();
    checkOutput("t4_jump_addr", imemaddr, 32'h8000_0040);
    jr_target = 32'h123;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, PC_JR);
    runCycle();
    checkOutput("t4_jr_addr", imemaddr, 32'h120);

    // PC wrap.
    resetCycle();
    runCycle();
    branch_target = 32'hFFFF_FFFC;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, PC_BRANCH);
    runCycle();
    checkOutput("t7_top_addr", imemaddr, 32'hFFFF_FFFC);
    runCycle();
    checkOutput("t7_wrap_addr", imemaddr, 32'h0);
    checkOutput("t7_wrap_npc", npc, 32'h0);

    // Halt beats a branch, holds until reset.
    resetCycle();
    runCycle();
    branch_target = 32'h40;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, PC_BRANCH);
    checkOutput("t5_halt_ren", imemREN, 0);
    for (int i = 0; i < 20; i++) begin
      runCycle();
      checkOutput("t5_halted_ren", imemREN, 0);
      checkOutput("t5_halted_valid", ins_valid, 0);
      checkOutput("t5_halted_pc", imemaddr, 32'h4);
    end
    resetCycle();
    checkOutput("t5_rst_ren", imemREN, 0);
    runCycle();
    checkOutput("t5_resume_addr", imemaddr, PC_INIT);
    checkOutput("t5_resume_ren", imemREN, 1);
    runCycle();
    checkOutput("t5_resume_ins", ins, 32'hBEEF_0000);

    // Reset in the middle of an outstanding request.
    resetCycle();
    runCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, PC_NEXT);
    checkOutput("t6_pending_ren", imemREN, 1);
    checkOutput("t6_pending_valid", ins_valid, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, PC_NEXT);
    checkOutput("t6_rst_ren", imemREN, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, PC_NEXT);
    checkOutput("t6_after_addr", imemaddr, PC_INIT);
    checkOutput("t6_after_valid", ins_valid, 0);
    runCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
